// File: rtl/scan_pkt_pkg.sv
// scan_pkt_pkg: shared state encoding, header and trailer field positions
package scan_pkt_pkg;
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        HDR   = 4'b0010,
        DATA  = 4'b0100,
        TRAIL = 4'b1000
    } state_t;
    localparam int HDR_SENSOR = 0;
    localparam int HDR_SCAN_HI = 1;
    localparam int HDR_SCAN_LO = 2;
    localparam int HDR_BEATS = 3;
    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_START_IGNORED = 1;
endpackage

// File: rtl/scan_pkt_tx_if.sv
// scan_pkt_tx_if: Avalon-ST packet stream between source and sink
interface scan_pkt_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic valid;
    logic ready;
    logic sop;
    logic eop;
    logic [DATA_WIDTH-1:0] data;
    modport master (output valid, sop, eop, data, input ready);
    modport slave (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/scan_pkt_fifo.sv
// scan_pkt_fifo: synchronous sample FIFO; pushes while full are dropped
module scan_pkt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic [WIDTH-1:0] push_data,
    input  logic pop,
    output logic [WIDTH-1:0] pop_data,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign pop_data = mem[rd_ptr];
    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
    // storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/scan_pkt_tx.sv
// scan_pkt_tx: frames a free-running sample stream into Avalon-ST scan packets
module scan_pkt_tx
    import scan_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SAMPLES_PER_SCAN = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic [DATA_WIDTH-1:0] sensor_type,
    input  logic sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    scan_pkt_tx_if.master data_output,
    output logic busy
);
    localparam int CW = $clog2(SAMPLES_PER_SCAN + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [CW-1:0] beat, beat_n, cap_cnt;
    logic cap_en;
    logic [31:0] scan, scan_n;
    logic ovf, ovf_n, sig, sig_n;
    logic v, v_n, sop, sop_n, eop, eop_n;
    logic [DATA_WIDTH-1:0] d, d_n, fifo_data, trailer;
    logic fifo_full, fifo_empty, push, drop, pop, can_load;
    logic [AW:0] fifo_count_unused;

    assign push = sample_valid && cap_en && !fifo_full;
    assign drop = sample_valid && cap_en && fifo_full;
    assign can_load = !v || data_output.ready;
    assign pop = can_load && !fifo_empty &&
                 ((state == DATA && beat != CW'(SAMPLES_PER_SCAN)) || (state == HDR && idx == 2'(HDR_BEATS)));
    assign busy = state != IDLE;
    assign data_output.valid = v;
    assign data_output.sop = sop;
    assign data_output.eop = eop;
    assign data_output.data = d;

    scan_pkt_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .push_data(sample_data),
        .pop(pop),
        .pop_data(fifo_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count_unused)
    );

    // capture window: opens after an accepted start, closes after a full scan of pushes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_en <= 1'b0;
            cap_cnt <= '0;
        end else if (state == IDLE && start) begin
            cap_en <= 1'b1;
            cap_cnt <= '0;
        end else if (push) begin
            cap_cnt <= cap_cnt + CW'(1);
            if (cap_cnt == CW'(SAMPLES_PER_SCAN - 1)) cap_en <= 1'b0;
        end
    end

    // packet state and the registered output beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx <= '0;
            beat <= '0;
            scan <= '0;
            ovf <= 1'b0;
            sig <= 1'b0;
            v <= 1'b0;
            sop <= 1'b0;
            eop <= 1'b0;
            d <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            beat <= beat_n;
            scan <= scan_n;
            ovf <= ovf_n;
            sig <= sig_n;
            v <= v_n;
            sop <= sop_n;
            eop <= eop_n;
            d <= d_n;
        end
    end

    // next-state and next-beat selection; the register only reloads when empty or accepted
    always_comb begin
        state_n = state;
        idx_n = idx;
        beat_n = beat;
        scan_n = scan;
        ovf_n = ovf || drop;
        sig_n = sig || (start && (state == HDR || state == DATA));
        v_n = v;
        sop_n = sop;
        eop_n = eop;
        d_n = d;
        trailer = '0;
        trailer[ERR_OVERFLOW] = ovf;
        trailer[ERR_START_IGNORED] = sig || start;
        case (state)
            IDLE: if (start) begin
                state_n = HDR;
                idx_n = 2'(HDR_SENSOR + 1);
                beat_n = '0;
                v_n = 1'b1;
                sop_n = 1'b1;
                eop_n = 1'b0;
                d_n = sensor_type;
            end
            HDR: if (can_load) begin
                sop_n = 1'b0;
                if (idx == 2'(HDR_BEATS)) begin
                    state_n = DATA;
                    v_n = pop;
                    d_n = pop ? fifo_data : d;
                    beat_n = beat + CW'(pop);
                end else begin
                    v_n = 1'b1;
                    d_n = idx == 2'(HDR_SCAN_HI) ? DATA_WIDTH'(scan[31:16]) : DATA_WIDTH'(scan[15:0]);
                    idx_n = idx + 2'd1;
                end
            end
            DATA: if (can_load) begin
                if (beat == CW'(SAMPLES_PER_SCAN)) begin
                    state_n = TRAIL;
                    v_n = 1'b1;
                    eop_n = 1'b1;
                    d_n = trailer;
                end else begin
                    v_n = pop;
                    d_n = pop ? fifo_data : d;
                    beat_n = beat + CW'(pop);
                end
            end
            TRAIL: if (can_load) begin
                state_n = IDLE;
                v_n = 1'b0;
                eop_n = 1'b0;
                scan_n = scan + 32'd1;
                ovf_n = 1'b0;
                sig_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_scan_pkt_tx.sv
// tb_scan_pkt_tx: directed checks of packet framing, back-pressure, overflow and reset
module tb_scan_pkt_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0, sv_a = 1'b0, busy_a;
    logic [15:0] sensor_a = 16'h00A5, sd_a = '0;
    logic start_b = 1'b0, sv_b = 1'b0, busy_b;
    logic [15:0] sensor_b = 16'h0033, sd_b = '0;
    logic tog_a = 1'b0;
    int checks = 0, errors = 0, ne_a = 0;
    int eop_a = 0, eop_b = 0, stall_err_a = 0, stall_err_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic [18:0] prev_a = '0, prev_b = '0;
    logic [17:0] qa[$], qb[$], exp_q[$];

    scan_pkt_tx_if #(.DATA_WIDTH(16)) if_a ();
    scan_pkt_tx_if #(.DATA_WIDTH(16)) if_b ();

    scan_pkt_tx #(.DATA_WIDTH(16), .SAMPLES_PER_SCAN(4), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .sensor_type(sensor_a),
        .sample_valid(sv_a), .sample_data(sd_a), .data_output(if_a), .busy(busy_a));
    scan_pkt_tx #(.DATA_WIDTH(16), .SAMPLES_PER_SCAN(8), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .sensor_type(sensor_b),
        .sample_valid(sv_b), .sample_data(sd_b), .data_output(if_b), .busy(busy_b));

    always #5 clk = ~clk;

    // beat logger and stall-stability watcher for each instance
    always @(negedge clk) begin
        if (reset_n && hold_a && {if_a.valid, if_a.sop, if_a.eop, if_a.data} !== prev_a) stall_err_a <= stall_err_a + 1;
        hold_a <= reset_n && if_a.valid && !if_a.ready;
        prev_a <= {if_a.valid, if_a.sop, if_a.eop, if_a.data};
        if (reset_n && if_a.valid && if_a.ready) begin
            qa.push_back({if_a.sop, if_a.eop, if_a.data});
            if (if_a.eop) eop_a <= eop_a + 1;
        end
        if (reset_n && hold_b && {if_b.valid, if_b.sop, if_b.eop, if_b.data} !== prev_b) stall_err_b <= stall_err_b + 1;
        hold_b <= reset_n && if_b.valid && !if_b.ready;
        prev_b <= {if_b.valid, if_b.sop, if_b.eop, if_b.data};
        if (reset_n && if_b.valid && if_b.ready) begin
            qb.push_back({if_b.sop, if_b.eop, if_b.data});
            if (if_b.eop) eop_b <= eop_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic st, input logic sv, input logic [15:0] sd);
        start_a = st; sv_a = sv; sd_a = sd;
        @(posedge clk); #1;
        start_a = 1'b0; sv_a = 1'b0;
        if (tog_a) if_a.ready = ~if_a.ready;
    endtask

    task automatic step_b(input logic st, input logic sv, input logic [15:0] sd);
        start_b = st; sv_b = sv; sd_b = sd;
        @(posedge clk); #1;
        start_b = 1'b0; sv_b = 1'b0;
    endtask

    task automatic wait_eop_a(input int n);
        int c = 0;
        while (eop_a < n && c < 200) begin step_a(0, 0, 0); c++; end
        chk("eop_timeout_a", 32'(eop_a >= n), 32'd1);
        repeat (2) step_a(0, 0, 0);
    endtask

    task automatic wait_eop_b(input int n);
        int c = 0;
        while (eop_b < n && c < 200) begin step_b(0, 0, 0); c++; end
        chk("eop_timeout_b", 32'(eop_b >= n), 32'd1);
        repeat (2) step_b(0, 0, 0);
    endtask

    task automatic add_pkt(input logic [15:0] sens, input logic [31:0] scan, input logic [15:0] first,
                           input int n, input logic [15:0] tr);
        exp_q.push_back({2'b10, sens});
        exp_q.push_back({2'b00, scan[31:16]});
        exp_q.push_back({2'b00, scan[15:0]});
        for (int i = 0; i < n; i++) exp_q.push_back({2'b00, first + 16'(i)});
        exp_q.push_back({2'b01, tr});
    endtask

    task automatic cmp(input string tag, input logic [17:0] got[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        exp_q = {};
    endtask

    task automatic run_basic_a(input logic [15:0] first);
        step_a(1, 0, 0);
        for (int i = 0; i < 4; i++) step_a(0, 1, first + 16'(i));
    endtask

    initial begin
        if_a.ready = 1'b1;
        if_b.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_a", {if_a.valid, if_a.sop, if_a.eop, if_a.data, busy_a}, '0);
        chk("reset_out_b", {if_b.valid, if_b.sop, if_b.eop, if_b.data, busy_b}, '0);
        reset_n = 1'b1;
        step_a(0, 0, 0);

        // basic packet, then a second one carrying scan count 1
        run_basic_a(16'd1);
        ne_a++; wait_eop_a(ne_a);
        add_pkt(16'h00A5, 32'd0, 16'd1, 4, 16'h0000);
        cmp("basic", qa); qa = {};
        run_basic_a(16'd5);
        ne_a++; wait_eop_a(ne_a);
        add_pkt(16'h00A5, 32'd1, 16'd5, 4, 16'h0000);
        cmp("second", qa); qa = {};

        // back-pressure with ready alternating every cycle
        tog_a = 1'b1;
        run_basic_a(16'd1);
        ne_a++; wait_eop_a(ne_a);
        tog_a = 1'b0; if_a.ready = 1'b1;
        add_pkt(16'h00A5, 32'd2, 16'd1, 4, 16'h0000);
        cmp("backpressure", qa); qa = {};
        chk("stall_stable_a", 32'(stall_err_a), 32'd0);

        // start pulsed during DATA is flagged and spawns nothing
        run_basic_a(16'd1);
        chk("busy_during_pkt", 32'(busy_a), 32'd1);
        step_a(1, 0, 0);
        ne_a++; wait_eop_a(ne_a);
        chk("busy_after_eop", 32'(busy_a), 32'd0);
        repeat (10) step_a(0, 0, 0);
        add_pkt(16'h00A5, 32'd3, 16'd1, 4, 16'h0002);
        cmp("start_busy", qa); qa = {};
        chk("busy_stays_idle", 32'(busy_a), 32'd0);

        // reset mid-packet aborts and restarts the scan counter
        run_basic_a(16'd1);
        step_a(0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("midreset_out", {if_a.valid, if_a.sop, if_a.eop, if_a.data, busy_a}, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        qa = {};
        ne_a = eop_a;
        step_a(0, 0, 0);
        run_basic_a(16'd5);
        ne_a++; wait_eop_a(ne_a);
        add_pkt(16'h00A5, 32'd0, 16'd5, 4, 16'h0000);
        cmp("after_reset", qa); qa = {};

        // samples before start are ignored and busy stays low
        for (int i = 0; i < 5; i++) begin
            step_a(0, 1, 16'h0100 + 16'(i));
            chk($sformatf("idle_busy%0d", i), 32'(busy_a), 32'd0);
        end
        chk("idle_no_beats", 32'(qa.size()), 32'd0);
        run_basic_a(16'd1);
        ne_a++; wait_eop_a(ne_a);
        add_pkt(16'h00A5, 32'd1, 16'd1, 4, 16'h0000);
        cmp("idle_samples", qa); qa = {};

        // overflow on the 8-sample, 4-deep instance
        step_b(1, 0, 0);
        chk("hdr_without_fifo", {if_b.valid, if_b.sop, if_b.eop, if_b.data}, {3'b110, 16'h0033});
        for (int i = 1; i <= 6; i++) step_b(0, 1, 16'(i));
        if_b.ready = 1'b1;
        repeat (12) step_b(0, 0, 0);
        for (int i = 7; i <= 10; i++) step_b(0, 1, 16'(i));
        wait_eop_b(1);
        exp_q.push_back({2'b10, 16'h0033});
        exp_q.push_back(18'h0);
        exp_q.push_back(18'h0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(18'(i));
        for (int i = 7; i <= 10; i++) exp_q.push_back(18'(i));
        exp_q.push_back({2'b01, 16'h0001});
        cmp("overflow", qb);
        chk("stall_stable_b", 32'(stall_err_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
